// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Contents:
//   rx_state_t      receiver FSM states
//   timer_width()   bit-timer counter width for a given bit period
//   params_ok()     legal-range check for the receiver parameters
//   parity_mismatch() parity verdict for a received word
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

  function automatic bit params_ok(input int data_w, input int clks_per_bit,
                                   input int stop_bits);
    return (data_w >= 5) && (data_w <= 9) &&
           (stop_bits >= 1) && (stop_bits <= 2) &&
           (clks_per_bit >= 8);
  endfunction

  // running is the XOR of all data bits; a correct frame makes
  // running ^ sampled equal to the configured polarity (0 even, 1 odd).
  function automatic logic parity_mismatch(input logic running, input logic sampled,
                                           input logic odd);
    return ((running ^ sampled) != odd) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_param_bit_timer.sv
// rx_bit_timer: loadable down-counter producing the mid-bit sample tick.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      reload the counter this cycle
//   half      on load, select the half-bit period instead of a full bit
//   tick      high while the counter sits at its terminal count (zero)
// At zero the counter reloads a full bit period by itself, so back-to-back
// bits in one state (and every tick-driven state change) start a fresh
// full period without an explicit load.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);

  logic [TW-1:0] count;

  // Down-counter with explicit load and automatic full-period reload at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= half ? HALF_TC : FULL_TC;
    end else if (count == '0) begin
      count <= FULL_TC;
    end else begin
      count <= count - TW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with valid/ready output.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   rx           serial line (idle high, asynchronous to clk)
//   rx_data      received word, LSB first on the line
//   rx_valid     rx_data and error flags are valid
//   rx_ready     consumer accepts the word when rx_valid & rx_ready
//   parity_err   parity mismatch for the presented word
//   frame_err    a stop bit was sampled low for the presented word
//   overrun_err  one-cycle pulse when a completed frame is dropped
//   busy         receiver is in any state other than IDLE
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy
);

  if (!params_ok(DATA_W, CLKS_PER_BIT, STOP_BITS)) begin : g_param_check
    $error("uart_rx_param: DATA_W, STOP_BITS or CLKS_PER_BIT out of range");
  end

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  logic              sync1;
  logic              rxs;
  rx_state_t         state;
  logic              armed;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic              par_acc;
  logic              par_err_lat;
  logic              frm_err_lat;
  logic              stop_cnt;
  logic              tick;
  logic              timer_load;
  logic              stop_low_seen;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Only the IDLE->START entry needs an explicit (half-period) load; every
  // other state entry happens on a tick, where the timer reloads itself.
  assign timer_load    = (state == IDLE) && armed && !rxs;
  // Frame error includes the stop sample being taken this cycle.
  assign stop_low_seen = frm_err_lat | ~rxs;

  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .half (timer_load),
    .tick (tick)
  );

  // Receiver FSM plus the registered output word, flags and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      armed       <= 1'b0;
      bit_idx     <= '0;
      shift       <= '0;
      par_acc     <= 1'b0;
      par_err_lat <= 1'b0;
      frm_err_lat <= 1'b0;
      stop_cnt    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      // Acceptance; a frame completing this same cycle overrides below.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (armed && !rxs) begin
            state       <= START;
            busy        <= 1'b1;
            armed       <= 1'b0;
            bit_idx     <= '0;
            par_acc     <= 1'b0;
            par_err_lat <= 1'b0;
            frm_err_lat <= 1'b0;
            stop_cnt    <= 1'b0;
          end else if (rxs) begin
            armed <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              // Glitch shorter than half a bit: back to idle, line is high.
              state <= IDLE;
              busy  <= 1'b0;
              armed <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift[bit_idx] <= rxs;
            par_acc        <= par_acc ^ rxs;
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
              end else begin
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            par_err_lat <= parity_mismatch(par_acc, rxs, ODD);
            state       <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              if (!rx_valid || rx_ready) begin
                rx_data    <= shift;
                parity_err <= par_err_lat;
                frame_err  <= stop_low_seen;
                rx_valid   <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
              if (stop_low_seen) begin
                // Hold off until the line returns high (break / stuck low).
                state <= WAIT_HIGH;
                armed <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                armed <= rxs;
              end
            end else begin
              stop_cnt    <= 1'b1;
              frm_err_lat <= stop_low_seen;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and controller, successor to the fixed-format Rx FSM in the Rx module. It synchronises the serial line and detects a start bit with glitch rejection. It samples every bit at mid-bit and checks optional even/odd parity and 1 or 2 stop bits. It presents each received word on a valid/ready interface with per-word error flags and overrun detection. It sits between the pad-side rx line and the Rx datapath consumer.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first
CLKS_PER_BIT, 868, clk cycles per bit (>= 8)
PARITY_EN, 1, 1 = parity bit present after data
PARITY_ODD, 0, 0 = even parity, 1 = odd (ignored if PARITY_EN = 0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_W  received word
rx_valid  out  1  rx_data and error flags valid
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
parity_err  out  1  parity mismatch for the presented word (qualified by rx_valid)
frame_err  out  1  a stop bit sampled low for the presented word (qualified by rx_valid)
overrun_err  out  1  one-cycle pulse: a frame completed while the previous word was unaccepted
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun_err = 0, busy = 0.
- Reset: synchroniser flops = 1, state = IDLE, armed = 0, counters = 0.
- Reset asserted mid-frame aborts the frame immediately; no partial word is ever presented.
- rx passes through a 2-FF synchroniser. rxs denotes the synchronised value, 2-cycle latency.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- Bit timer: counter width $clog2(CLKS_PER_BIT). It reloads on every state entry and raises tick at its terminal count.
- START terminal count: CLKS_PER_BIT/2 - 1. All other states: CLKS_PER_BIT - 1.
- IDLE: armed is set when rxs = 1. When armed and rxs = 0, go to START.
- START: at tick, sample rxs.
  - rxs = 1: false start; go to IDLE, no output.
  - rxs = 0: go to DATA with bit index = 0.
- DATA: at each tick, shift rxs into bit [index] (LSB first) and update the running parity.
  - After bit DATA_W-1, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: at tick, compute mismatch = (XOR of data bits ^ sampled bit) != PARITY_ODD. Go to STOP.
- STOP: at each tick, sample rxs. Any 0 sets the frame-error latch.
  - After STOP_BITS samples, the frame completes: go to IDLE (armed kept if last sample = 1), or to WAIT_HIGH if the frame-error latch is set.
- WAIT_HIGH: stay until rxs = 1, then go to IDLE with armed = 1. This prevents a break or low line from re-triggering a frame.
- Frame completion, output register update:
  - If rx_valid = 0, or rx_valid & rx_ready in the same cycle: load rx_data, parity_err and frame_err. rx_valid = 1 on the next cycle.
  - Otherwise: new word dropped, old word and flags held, overrun_err = 1 for exactly one cycle.
- Latency: rx_valid rises 1 cycle after the final stop-bit tick. Counted from the first clk edge where rxs = 0, that is CLKS_PER_BIT/2 + (DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Acceptance: rx_valid stays high until a cycle with rx_ready = 1, then clears on the next cycle unless a new frame completes in that same cycle.
- rx_ready has no effect while rx_valid = 0.

Decomposition:
- Package uart_rx_pkg:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}
  - localparam function for the bit-timer width
  - parameter-range checks (DATA_W 5..9, STOP_BITS 1..2, CLKS_PER_BIT >= 8)
- One sub-module, rx_bit_timer: loadable down-counter with a terminal-count tick output. It is parametrised by CLKS_PER_BIT and selects full or half period on load.

Test Plan:
(bench: CLKS_PER_BIT = 16, DATA_W = 8, PARITY_EN = 1, PARITY_ODD = 0, STOP_BITS = 1)
- Frame 0xA5 (parity bit 0, stop 1), rx_ready = 1 -> rx_data = 0xA5, parity_err = 0, frame_err = 0, rx_valid high 1 cycle, exactly 168 cycles after the first rxs = 0 cycle.
- rx low for 4 cycles then high -> no rx_valid; busy returns to 0 by cycle 8; a following frame 0x3C is received correctly.
- Frame 0x01 with parity bit 0 (wrong) -> rx_data = 0x01, parity_err = 1, frame_err = 0.
- Frame 0x55 with stop bit 0, then rx held low 40 cycles, then high, then frame 0x7E -> first word has frame_err = 1; no spurious start during the low period; second word is 0x7E with no errors.
- Frames 0x11 then 0x22 back-to-back, rx_ready = 0 -> rx_data stays 0x11, overrun_err pulses once at the second frame's completion. rx_ready = 1 afterwards -> rx_valid drops, no 0x22 presented.
- rst pulsed during DATA bit 3 -> all outputs 0 immediately, busy = 0; next frame 0xC3 received correctly.
